fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that produces the instruction stream consumed by `decode`. It keeps the program counter and issues word reads to instruction memory with a valid/ready request and a valid response. Returned words are buffered with their PC in a small queue and presented to `decode` as `instr_out`/`pc_out`/`valid_out`, honouring decode back-pressure. It accepts PC redirects from `execute` (branch/jump) and flushes stale instructions.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC of the first fetch after reset.
- `DEPTH`, 2, number of instruction-queue entries (≥2, power of two).

Ports:
- `req`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  one clock; reset is synchronous and active-low.
- `imem_valid_out`  out  1  read request valid.
- `imem_addr_out`  out  32  read address (word-aligned; equals current PC).
- `imem_ready_in`  in  1  memory accepts the request this cycle.
- `imem_rsp_valid_in`  in  1  read data valid.
- `imem_rsp_data_in`  in  32  read data.
- `stall_in`  in  1  decode cannot accept an instruction this cycle.
- `valid_out`  out  1  `instr_out`/`pc_out` hold a real instruction.
- `instr_out`  out  32  instruction to decode.
- `pc_out`  out  32  PC of `instr_out`.
- `branch_in`  in  1  redirect request from execute.
- `branch_pc_in`  in  32  redirect target; bits [1:0] ignored (forced 0).

## Operation
- FSM states: FETCH, WAIT, DRAIN. At most one memory request outstanding.
- FETCH: `imem_valid_out` = (count < DEPTH). On `imem_valid_out && imem_ready_in`: latch request PC, PC += 4 (mod 2^32, wraps 32'hFFFF_FFFC → 0), go WAIT. Once asserted, `imem_valid_out` and `imem_addr_out` stay stable until accepted, except on redirect.
- WAIT: `imem_valid_out` = 0. On `imem_rsp_valid_in`: push {latched PC, data} into queue, go FETCH.
- DRAIN: `imem_valid_out` = 0. On `imem_rsp_valid_in`: discard data, go FETCH.
- Queue output: `valid_out` = (count ≠ 0); `instr_out`/`pc_out` = head entry; when empty, `instr_out` = NOP 32'h0000_0013, `pc_out` = 0.
- Pop when `valid_out && !stall_in`. Push and pop in the same cycle: count unchanged.
- Redirect (`branch_in`=1), highest priority: queue flushed (count = 0, this cycle's pop/push ignored); PC ← {branch_pc_in[31:2], 2'b00}. If in WAIT, or in FETCH with the request accepted this same cycle, go DRAIN; a response arriving in the redirect cycle itself is discarded and the FSM goes FETCH (not DRAIN). Otherwise go FETCH.
- Redirect in DRAIN: PC updated, stays DRAIN (unless the response arrives that cycle → FETCH).

## Timing
- Reset (`reset`=0 at a rising edge): state FETCH, PC = RESET_PC, count = 0, read/write pointers 0. Outputs then: `valid_out`=0, `instr_out`=32'h0000_0013, `pc_out`=0, `imem_valid_out`=1, `imem_addr_out`=RESET_PC. Reset mid-transaction abandons any outstanding request; a response arriving during or after reset while in FETCH is ignored.
- First request visible in the cycle after reset deasserts.
- Response-to-`valid_out` latency: 1 cycle (registered push, no bypass).
- Peak throughput with single-cycle memory: one instruction per 2 cycles.
- Redirect-to-new-request: the new address appears on `imem_addr_out` the cycle after `branch_in` (FETCH), or the cycle after the stale response (DRAIN).
- `imem_rsp_valid_in` while in FETCH is ignored (protocol error, no state change).

## Structure
- Package `fetch_pkg`: state enum {FETCH, WAIT, DRAIN}, `NOP_INSTR` = 32'h0000_0013, default `RESET_PC`.
- Sub-module `fetch_queue`: DEPTH-entry FIFO of {pc[31:0], instr[31:0]} with push, pop, flush, count, and head outputs; the FSM and PC live in `fetch_unit`.

## Test plan
- Reset then single-cycle memory returning 32'h0010_8093 at 0x0, 32'h0010_8133 at 0x4 → `valid_out` pulses with `pc_out`=0x0 then 0x4; `instr_out` matches; requests every 2 cycles.
- `stall_in`=1 held for 10 cycles → exactly DEPTH=2 entries fetched (0x0, 0x4); `imem_valid_out` low while full; release → 0x0, 0x4, 0x8 delivered in order with none lost or duplicated.
- `imem_ready_in` low for 3 cycles → `imem_valid_out`=1, `imem_addr_out`=0x0 stable throughout; PC advances only on acceptance.
- `branch_in`=1, `branch_pc_in`=32'h0000_0102 while in WAIT → queue emptied, next response discarded, next request addr 32'h0000_0100, first delivered `pc_out`=0x100.
- Branch in the same cycle as a pop and a response → no instruction delivered from old path, `valid_out`=0 next cycle, FSM in FETCH.
- PC at 32'hFFFF_FFFC → next request addr 32'h0000_0000; `reset`=0 in WAIT → outputs return to reset values, late response ignored.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  // Fetch FSM: issue a request, wait for its data, or swallow a stale response.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // addi x0, x0, 0 -- presented to decode whenever the queue is empty.
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Word-align a redirect target; the two low bits carry no meaning.
  function automatic logic [31:0] align_pc(input logic [31:0] target);
    return {target[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetched {pc, instr} pairs sitting between memory and decode.
// Flush empties it in one cycle and overrides any push/pop that cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [31:0]              push_pc,
  input  logic [31:0]              push_instr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic [31:0]              head_pc,
  output logic [31:0]              head_instr
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;
  fetch_entry_t   head;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Qualify push/pop: flush wins, a full queue only accepts alongside a pop.
  always_comb begin
    do_pop  = pop && !flush && !empty;
    do_push = push && !flush && (!full || do_pop);
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= '{pc: push_pc, instr: push_instr};
  end

  // Head presentation: an empty queue shows a NOP at address zero.
  always_comb begin
    head       = mem[rd_ptr];
    head_pc    = empty ? 32'h0000_0000 : head.pc;
    head_instr = empty ? NOP_INSTR     : head.instr;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word read at a time,
// buffers returned words for decode and handles redirects from execute.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = fetch_pkg::DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        req,
  input  logic        reset,
  output logic        imem_valid_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ready_in,
  input  logic        imem_rsp_valid_in,
  input  logic [31:0] imem_rsp_data_in,
  input  logic        stall_in,
  output logic        valid_out,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  input  logic        branch_in,
  input  logic [31:0] branch_pc_in
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t    state;
  logic [31:0]     pc;
  logic [31:0]     req_pc;
  logic [CW-1:0]   count;
  logic            q_empty;
  logic            q_full;
  logic            accept;
  logic            push;
  logic            pop;
  logic [31:0]     target;

  // Request only while idle in FETCH and there is room for the answer, so a
  // response can always be pushed; count cannot fall into FETCH-hold, which
  // keeps the request stable until memory takes it.
  always_comb begin
    imem_valid_out = (state == FETCH) && !q_full;
    imem_addr_out  = pc;
    accept         = imem_valid_out && imem_ready_in;
    push           = (state == WAIT) && imem_rsp_valid_in && !branch_in;
    pop            = valid_out && !stall_in && !branch_in;
    target         = align_pc(branch_pc_in);
  end

  // Fetch FSM and PC; a redirect overrides everything except reset.
  always_ff @(posedge req) begin
    if (!reset) begin
      state <= FETCH;
      pc    <= RESET_PC;
    end else if (branch_in) begin
      pc <= target;
      unique case (state)
        // A request taken this cycle still owes a response that must be dropped.
        FETCH:       state <= accept ? DRAIN : FETCH;
        // The outstanding response either lands now (dropped) or later (drain).
        WAIT, DRAIN: state <= imem_rsp_valid_in ? FETCH : DRAIN;
        default:     state <= FETCH;
      endcase
    end else begin
      unique case (state)
        FETCH: begin
          if (accept) begin
            pc    <= pc + 32'd4;
            state <= WAIT;
          end
        end
        WAIT:    if (imem_rsp_valid_in) state <= FETCH;
        DRAIN:   if (imem_rsp_valid_in) state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  // Remember which address the outstanding request was for.
  always_ff @(posedge req) begin
    if (accept && !branch_in) req_pc <= pc;
  end

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk        (req),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (branch_in),
    .push_pc    (req_pc),
    .push_instr (imem_rsp_data_in),
    .count      (count),
    .empty      (q_empty),
    .full       (q_full),
    .head_pc    (pc_out),
    .head_instr (instr_out)
  );

  assign valid_out = !q_empty;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a single-cycle memory model answers accepted
// requests unless the sequence takes manual control of the response port.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_valid_out;
  logic [31:0] imem_addr_out;
  logic        imem_ready_in;
  logic        imem_rsp_valid_in;
  logic [31:0] imem_rsp_data_in;
  logic        stall_in;
  logic        valid_out;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        branch_in;
  logic [31:0] branch_pc_in;

  int checks   = 0;
  int failures = 0;
  logic auto_mem;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .req               (clk),
    .reset             (reset),
    .imem_valid_out    (imem_valid_out),
    .imem_addr_out     (imem_addr_out),
    .imem_ready_in     (imem_ready_in),
    .imem_rsp_valid_in (imem_rsp_valid_in),
    .imem_rsp_data_in  (imem_rsp_data_in),
    .stall_in          (stall_in),
    .valid_out         (valid_out),
    .instr_out         (instr_out),
    .pc_out            (pc_out),
    .branch_in         (branch_in),
    .branch_pc_in      (branch_pc_in)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0)      return 32'h0010_8093;
    else if (a == 32'h4) return 32'h0010_8133;
    else                 return 32'hA000_0000 | a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample #1 after the edge and drive the memory answer.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    acc = reset && imem_valid_out && imem_ready_in;
    a   = imem_addr_out;
    @(posedge clk);
    #1;
    if (auto_mem) begin
      imem_rsp_valid_in = acc;
      imem_rsp_data_in  = mem_word(a);
    end
  endtask

  initial begin
    reset = 1'b0; imem_ready_in = 1'b1; imem_rsp_valid_in = 1'b0;
    imem_rsp_data_in = '0; stall_in = 1'b0; branch_in = 1'b0;
    branch_pc_in = '0; auto_mem = 1'b1;

    // Reset state
    tick(); tick();
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_instr", instr_out, NOP);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_imem_valid", 32'(imem_valid_out), 32'd1);
    chk("rst_imem_addr", imem_addr_out, 32'h0);

    // Streaming with single-cycle memory
    reset = 1'b1;
    tick();                                             // accept 0x0
    chk("s_req_gap0", 32'(imem_valid_out), 32'd0);
    tick();                                             // push 0x0
    chk("s_valid0", 32'(valid_out), 32'd1);
    chk("s_pc0", pc_out, 32'h0);
    chk("s_instr0", instr_out, 32'h0010_8093);
    chk("s_req1", 32'(imem_valid_out), 32'd1);
    chk("s_addr1", imem_addr_out, 32'h4);
    tick();                                             // pop 0x0, accept 0x4
    chk("s_valid_gap", 32'(valid_out), 32'd0);
    chk("s_req_gap1", 32'(imem_valid_out), 32'd0);
    tick();                                             // push 0x4
    chk("s_pc4", pc_out, 32'h4);
    chk("s_instr4", instr_out, 32'h0010_8133);
    chk("s_addr8", imem_addr_out, 32'h8);

    // Back-pressure from decode fills the queue and stops requests
    reset = 1'b0; stall_in = 1'b1;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("st_full_req", 32'(imem_valid_out), 32'd0);
    chk("st_pc_head", pc_out, 32'h0);
    chk("st_instr_head", instr_out, 32'h0010_8093);
    chk("st_pc_next", imem_addr_out, 32'h8);
    stall_in = 1'b0;
    tick();
    chk("st_rel_pc4", pc_out, 32'h4);
    chk("st_rel_instr4", instr_out, 32'h0010_8133);
    tick();
    chk("st_rel_empty", 32'(valid_out), 32'd0);
    tick();
    chk("st_rel_pc8", pc_out, 32'h8);
    chk("st_rel_instr8", instr_out, 32'hA000_0008);

    // Memory not ready: request held stable
    imem_ready_in = 1'b0; stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("nr_valid", 32'(imem_valid_out), 32'd1);
      chk("nr_addr", imem_addr_out, 32'hC);
    end
    imem_ready_in = 1'b1;
    tick();                                             // accept 0xC
    chk("nr_accepted", 32'(imem_valid_out), 32'd0);

    // Redirect while waiting; the late response must be dropped
    auto_mem = 1'b0; imem_rsp_valid_in = 1'b0;
    branch_in = 1'b1; branch_pc_in = 32'h0000_0102;
    tick();
    branch_in = 1'b0;
    chk("br_flush_valid", 32'(valid_out), 32'd0);
    chk("br_flush_instr", instr_out, NOP);
    chk("br_drain_req", 32'(imem_valid_out), 32'd0);
    imem_rsp_valid_in = 1'b1; imem_rsp_data_in = 32'hDEAD_BEEF;
    tick();
    chk("br_stale_dropped", 32'(valid_out), 32'd0);
    chk("br_new_req", 32'(imem_valid_out), 32'd1);
    chk("br_new_addr", imem_addr_out, 32'h100);
    imem_rsp_valid_in = 1'b0; auto_mem = 1'b1; stall_in = 1'b0;
    tick(); tick();
    chk("br_first_pc", pc_out, 32'h100);
    chk("br_first_instr", instr_out, 32'hA000_0100);

    // Redirect coinciding with a pop and a response
    stall_in = 1'b1;
    tick();                                             // accept 0x104, queue holds 0x100
    stall_in = 1'b0; branch_in = 1'b1; branch_pc_in = 32'h0000_0200;
    tick();
    branch_in = 1'b0;
    chk("bc_valid", 32'(valid_out), 32'd0);
    chk("bc_pc_out", pc_out, 32'h0);
    chk("bc_fetch_req", 32'(imem_valid_out), 32'd1);
    chk("bc_addr", imem_addr_out, 32'h200);
    tick(); tick();
    chk("bc_first_pc", pc_out, 32'h200);

    // Redirect on an accepted request, then PC wrap-around
    stall_in = 1'b1; branch_in = 1'b1; branch_pc_in = 32'hFFFF_FFFF;
    tick();
    branch_in = 1'b0;
    chk("wr_drain_req", 32'(imem_valid_out), 32'd0);
    chk("wr_flushed", 32'(valid_out), 32'd0);
    tick();                                             // stale response drained
    chk("wr_addr_top", imem_addr_out, 32'hFFFF_FFFC);
    tick(); tick();
    chk("wr_pc_top", pc_out, 32'hFFFF_FFFC);
    chk("wr_addr_wrap", imem_addr_out, 32'h0000_0000);
    chk("wr_req_wrap", 32'(imem_valid_out), 32'd1);

    // Reset in WAIT with a late response
    tick();                                             // accept 0x0, now WAIT
    reset = 1'b0;
    tick();
    chk("rw_valid_out", 32'(valid_out), 32'd0);
    chk("rw_instr", instr_out, NOP);
    chk("rw_pc_out", pc_out, 32'h0);
    chk("rw_imem_valid", 32'(imem_valid_out), 32'd1);
    chk("rw_imem_addr", imem_addr_out, 32'h0);
    auto_mem = 1'b0; reset = 1'b1; imem_ready_in = 1'b0;
    imem_rsp_valid_in = 1'b1; imem_rsp_data_in = 32'h1234_5678;
    tick();
    imem_rsp_valid_in = 1'b0;
    chk("rw_late_ignored", 32'(valid_out), 32'd0);
    chk("rw_still_fetch", 32'(imem_valid_out), 32'd1);
    chk("rw_addr_hold", imem_addr_out, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
